match_logger: RTL and testbench
===============================

# match_logger

Downstream consumer of the sequence detector's `match` output. It timestamps each detection with a free-running cycle counter, maintains a saturating total match count, and buffers {timestamp, count} records in a small FIFO. A host or checker drains the FIFO through a valid/ready interface. A sticky flag records any detection lost because the FIFO was full.

## Interface

Parameters:
- `CNT_WIDTH`, 16: width of the saturating match counter and of `out_count`.
- `TS_WIDTH`, 16: width of the free-running timestamp counter and of `out_ts`.
- `DEPTH`, 4: FIFO depth in records. Power of two, minimum 2.

Ports:
- `clk`  input  1  clock; all logic on rising edge. One clock; reset is synchronous and active-high.
- `reset`  input  1  synchronous active-high reset.
- `match`  input  1  detector match; one event per cycle high.
- `clear`  input  1  synchronous soft clear of count, FIFO and overflow flag.
- `out_valid`  output  1  head record available.
- `out_ready`  input  1  consumer accepts head record.
- `out_ts`  output  TS_WIDTH  timestamp of head record.
- `out_count`  output  CNT_WIDTH  match count carried by head record.
- `match_total`  output  CNT_WIDTH  live saturating match count.
- `fill`  output  $clog2(DEPTH)+1  number of records held, 0..DEPTH.
- `overflow`  output  1  sticky: a record was dropped.

## Operation

- Timestamp `ts`: increments by 1 every cycle and wraps from all-ones to 0. Only `reset` affects it; `clear` does not.
- Event: `match`=1 at a rising edge.
- Counter on an event: `match_total` ← `match_total`+1, saturating at 2^CNT_WIDTH−1. At saturation it holds and further events are still logged.
- Push on an event: the record is {ts as sampled at that edge (pre-increment value), updated `match_total`}.
  - If the FIFO is not full, the record is written.
  - If the FIFO is full and no pop occurs that cycle, the record is dropped and `overflow` ← 1. The count still increments.
- Pop occurs when `out_valid` && `out_ready` at an edge. The head record is removed.
- Simultaneous push and pop:
  - FIFO full: pop frees a slot, push is accepted, `fill` is unchanged, no overflow.
  - FIFO empty: no pop (`out_valid`=0), push is accepted, `fill` becomes 1.
- `out_valid` = (`fill` != 0). `out_ts` and `out_count` are the head record. Their values are don't-care when `out_valid`=0, but must be stable while `out_valid`=1 and `out_ready`=0.
- Records leave in strict FIFO order. Read and write pointers wrap modulo DEPTH; `fill` distinguishes full from empty.
- `clear` takes priority over `match` and the handshake in the same cycle:
  - Resulting state: `fill`=0, `match_total`=0, `overflow`=0.
  - The coincident event is discarded and not counted.
  - Any handshake that cycle is ignored.
- `reset` takes priority over `clear`. Applied mid-operation, it discards all buffered records.

## Timing

- Reset values after the first edge with `reset`=1: `ts`=0, `match_total`=0, `fill`=0, `out_valid`=0, `overflow`=0.
- Latency: event at edge N with an empty FIFO gives `out_valid`=1 and the record on outputs from edge N onward (visible in cycle N+1). There is no combinational path from `match` to any output.
- `match_total` and `fill` update at the same edge as the event or pop.
- `out_ready` only affects state at edges. `out_valid` never depends combinationally on `out_ready`.
- Throughput: one push and one pop per cycle sustained.

## Test plan

- Reset, then `match` pulses at cycles 5, 9, 20 with `out_ready`=1 → records (ts,count) = (5,1), (9,2), (20,3). Each `out_valid` lasts one cycle, starting the cycle after its event.
- `out_ready`=0 with 6 events, DEPTH=4 → `fill`=4 after event 4, `overflow`=1 after event 5, `match_total`=6. Draining yields counts 1..4 only.
- FIFO full, event and pop in the same cycle → `fill` stays 4, `overflow` stays 0, new record at tail.
- CNT_WIDTH=4 with 17 events drained continuously → `match_total`=15 from event 15 on. Records 15–17 all carry count 15.
- `clear` asserted coincident with `match` while `fill`=3 and `overflow`=1 → next cycle `fill`=0, `match_total`=0, `overflow`=0, `out_valid`=0. `ts` continues unchanged.
- TS_WIDTH=4, events at cycles 14 and 17 → timestamps 14 and 1, showing wrap.

Source files
------------

// File: rtl/match_logger.sv
// Timestamps detector matches, keeps a saturating match count and queues
// {timestamp, count} records in a small FIFO drained over valid/ready.
module match_logger #(
  parameter int CNT_WIDTH = 16,
  parameter int TS_WIDTH  = 16,
  parameter int DEPTH     = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     match,
  input  logic                     clear,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [TS_WIDTH-1:0]      out_ts,
  output logic [CNT_WIDTH-1:0]     out_count,
  output logic [CNT_WIDTH-1:0]     match_total,
  output logic [$clog2(DEPTH):0]   fill,
  output logic                     overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int REC_W = TS_WIDTH + CNT_WIDTH;
  localparam logic [PTR_W:0] FULL_LVL = (PTR_W + 1)'(DEPTH);

  logic [TS_WIDTH-1:0]  ts_q, ts_d;
  logic [CNT_WIDTH-1:0] total_q, total_d;
  logic [PTR_W:0]       fill_q, fill_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic                 ovf_q, ovf_d;
  logic [REC_W-1:0]     mem_q [DEPTH];

  logic                 pop;
  logic                 full;
  logic                 wr_en;
  logic [REC_W-1:0]     wr_data;
  logic [CNT_WIDTH-1:0] total_inc;

  always_comb begin
    ts_d      = ts_q + TS_WIDTH'(1);
    total_d   = total_q;
    fill_d    = fill_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    ovf_d     = ovf_q;
    wr_en     = 1'b0;
    pop       = (fill_q != '0) && out_ready;
    full      = (fill_q == FULL_LVL);
    total_inc = (total_q == '1) ? total_q : total_q + CNT_WIDTH'(1);
    wr_data   = {ts_q, total_inc};

    if (clear) begin
      // Soft clear wins over any coincident event or handshake.
      total_d  = '0;
      fill_d   = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      ovf_d    = 1'b0;
    end else begin
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (match) begin
        total_d = total_inc;
        // A pop in the same cycle frees the slot this push needs.
        if (!full || pop) begin
          wr_en    = 1'b1;
          wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
          ovf_d = 1'b1;
        end
      end
      case ({wr_en, pop})
        2'b10:   fill_d = fill_q + (PTR_W + 1)'(1);
        2'b01:   fill_d = fill_q - (PTR_W + 1)'(1);
        default: fill_d = fill_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ts_q     <= '0;
      total_q  <= '0;
      fill_q   <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      ts_q     <= ts_d;
      total_q  <= total_d;
      fill_q   <= fill_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      ovf_q    <= ovf_d;
    end
  end

  // Record storage needs no reset: fill_q alone says which entries are live.
  always_ff @(posedge clk) begin
    if (wr_en && !reset) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign out_valid   = (fill_q != '0);
  assign out_ts      = mem_q[rd_ptr_q][REC_W-1:CNT_WIDTH];
  assign out_count   = mem_q[rd_ptr_q][CNT_WIDTH-1:0];
  assign match_total = total_q;
  assign fill        = fill_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_match_logger.sv
// Randomised and directed checks of match_logger against a queue-based model;
// instance a uses default widths, instance b uses 4-bit count and timestamp.
module tb_match_logger;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic m_a = 1'b0, c_a = 1'b0, r_a = 1'b0;
  logic m_b = 1'b0, c_b = 1'b0, r_b = 1'b0;

  logic        v_a, ovf_a;
  logic [15:0] ts_a, cnt_a, tot_a;
  logic [2:0]  fill_a;
  logic        v_b, ovf_b;
  logic [3:0]  ts_b, cnt_b, tot_b;
  logic [2:0]  fill_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  match_logger #(.CNT_WIDTH(16), .TS_WIDTH(16), .DEPTH(4)) dut_a (
    .clk(clk), .reset(reset), .match(m_a), .clear(c_a),
    .out_valid(v_a), .out_ready(r_a), .out_ts(ts_a), .out_count(cnt_a),
    .match_total(tot_a), .fill(fill_a), .overflow(ovf_a)
  );

  match_logger #(.CNT_WIDTH(4), .TS_WIDTH(4), .DEPTH(4)) dut_b (
    .clk(clk), .reset(reset), .match(m_b), .clear(c_b),
    .out_valid(v_b), .out_ready(r_b), .out_ts(ts_b), .out_count(cnt_b),
    .match_total(tot_b), .fill(fill_b), .overflow(ovf_b)
  );

  // Observed state packed as {valid, head ts, head count, total, fill, overflow};
  // head fields read as zero when nothing is held.
  logic [52:0] obs_a, obs_b;
  assign obs_a = {v_a, v_a ? ts_a : 16'h0, v_a ? cnt_a : 16'h0, tot_a, fill_a, ovf_a};
  assign obs_b = {v_b, v_b ? {12'h0, ts_b} : 16'h0, v_b ? {12'h0, cnt_b} : 16'h0,
                  {12'h0, tot_b}, fill_b, ovf_b};

  // Reference model: a cycle counter, a saturating total and a queue of records.
  int unsigned ts_m[2];
  int unsigned tot_m[2];
  bit          ovf_m[2];
  int unsigned qts[2][$];
  int unsigned qcnt[2][$];
  int unsigned ts_mask[2] = '{32'hFFFF, 32'hF};
  int unsigned cnt_max[2] = '{32'hFFFF, 32'hF};

  task automatic model_edge(input int i, input bit m, input bit c, input bit rd);
    int unsigned tmp;
    if (reset) begin
      ts_m[i] = 0; tot_m[i] = 0; ovf_m[i] = 0;
      qts[i].delete(); qcnt[i].delete();
    end else begin
      if (c) begin
        tot_m[i] = 0; ovf_m[i] = 0;
        qts[i].delete(); qcnt[i].delete();
      end else begin
        if (rd && qts[i].size() != 0) begin
          tmp = qts[i].pop_front();
          tmp = qcnt[i].pop_front();
        end
        if (m) begin
          if (tot_m[i] < cnt_max[i]) tot_m[i] = tot_m[i] + 1;
          if (qts[i].size() < 4) begin
            qts[i].push_back(ts_m[i]);
            qcnt[i].push_back(tot_m[i]);
          end else begin
            ovf_m[i] = 1;
          end
        end
      end
      ts_m[i] = (ts_m[i] + 1) & ts_mask[i];
    end
  endtask

  function automatic logic [52:0] exp_vec(input int i);
    logic v;
    logic [15:0] hts, hcnt;
    v = (qts[i].size() != 0);
    hts = 16'h0;
    hcnt = 16'h0;
    if (v) begin
      hts = 16'(qts[i][0]);
      hcnt = 16'(qcnt[i][0]);
    end
    return {v, hts, hcnt, 16'(tot_m[i]), 3'(qts[i].size()), ovf_m[i]};
  endfunction

  task automatic tick();
    model_edge(0, m_a, c_a, r_a);
    model_edge(1, m_b, c_b, r_b);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m_a = 0; c_a = 0; r_a = 0;
    m_b = 0; c_b = 0; r_b = 0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    reset = 1;
    tick();
    reset = 0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (obs_a !== 53'h0) begin
      errors++;
      $display("FAIL reset_a: got %h expected %h", obs_a, 53'h0);
    end
    checks++;
    if (obs_b !== 53'h0) begin
      errors++;
      $display("FAIL reset_b: got %h expected %h", obs_b, 53'h0);
    end
  endtask

  task automatic test_basic();
    int k;
    apply_reset();
    r_a = 1;
    k = 0;
    for (int cyc = 0; cyc <= 22; cyc++) begin
      m_a = (cyc == 5 || cyc == 9 || cyc == 20);
      tick();
      checks++;
      if (obs_a !== exp_vec(0)) begin
        errors++;
        $display("FAIL basic cyc %0d: got %h expected %h", cyc, obs_a, exp_vec(0));
      end
      if (m_a) begin
        k++;
        checks++;
        if (!(v_a === 1'b1 && ts_a === 16'(cyc) && cnt_a === 16'(k))) begin
          errors++;
          $display("FAIL basic_record %0d: got v=%b ts=%0d cnt=%0d expected v=1 ts=%0d cnt=%0d",
                   k, v_a, ts_a, cnt_a, cyc, k);
        end
      end
    end
    idle_inputs();
  endtask

  task automatic test_overflow();
    apply_reset();
    for (int k = 1; k <= 6; k++) begin
      m_a = 1;
      tick();
      checks++;
      if (obs_a !== exp_vec(0)) begin
        errors++;
        $display("FAIL overflow ev %0d: got %h expected %h", k, obs_a, exp_vec(0));
      end
      checks++;
      if (fill_a !== 3'd4 && k >= 4 || ovf_a !== (k >= 5) || tot_a !== 16'(k)) begin
        errors++;
        $display("FAIL overflow_flags ev %0d: got fill=%0d ovf=%b total=%0d expected fill>=%0d ovf=%b total=%0d",
                 k, fill_a, ovf_a, tot_a, (k < 4) ? k : 4, k >= 5, k);
      end
    end
    m_a = 0;
    r_a = 1;
    for (int k = 1; k <= 4; k++) begin
      checks++;
      if (!(v_a === 1'b1 && cnt_a === 16'(k))) begin
        errors++;
        $display("FAIL overflow_drain %0d: got v=%b cnt=%0d expected v=1 cnt=%0d", k, v_a, cnt_a, k);
      end
      tick();
    end
    checks++;
    if (v_a !== 1'b0 || obs_a !== exp_vec(0)) begin
      errors++;
      $display("FAIL overflow_empty: got %h expected %h", obs_a, exp_vec(0));
    end
    idle_inputs();
  endtask

  task automatic test_full_pop();
    apply_reset();
    m_a = 1;
    repeat (4) tick();
    r_a = 1;
    tick();
    checks++;
    if (fill_a !== 3'd4 || ovf_a !== 1'b0 || cnt_a !== 16'd2 || obs_a !== exp_vec(0)) begin
      errors++;
      $display("FAIL full_pop: got fill=%0d ovf=%b head=%0d (%h) expected fill=4 ovf=0 head=2 (%h)",
               fill_a, ovf_a, cnt_a, obs_a, exp_vec(0));
    end
    m_a = 0;
    for (int k = 2; k <= 5; k++) begin
      checks++;
      if (cnt_a !== 16'(k)) begin
        errors++;
        $display("FAIL full_pop_order %0d: got cnt=%0d expected %0d", k, cnt_a, k);
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_clear();
    int unsigned t_clear;
    apply_reset();
    m_a = 1;
    repeat (5) tick();
    m_a = 0;
    r_a = 1;
    tick();
    checks++;
    if (fill_a !== 3'd3 || ovf_a !== 1'b1) begin
      errors++;
      $display("FAIL clear_setup: got fill=%0d ovf=%b expected fill=3 ovf=1", fill_a, ovf_a);
    end
    m_a = 1; c_a = 1;
    t_clear = ts_m[0];
    tick();
    checks++;
    if (obs_a !== 53'h0 || obs_a !== exp_vec(0)) begin
      errors++;
      $display("FAIL clear_state: got %h expected %h", obs_a, 53'h0);
    end
    c_a = 0; r_a = 0;
    tick();
    checks++;
    if (!(v_a === 1'b1 && cnt_a === 16'd1 && tot_a === 16'd1 && ts_a === 16'(t_clear + 1))) begin
      errors++;
      $display("FAIL clear_after: got v=%b cnt=%0d total=%0d ts=%0d expected v=1 cnt=1 total=1 ts=%0d",
               v_a, cnt_a, tot_a, ts_a, t_clear + 1);
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    m_a = 1;
    repeat (3) tick();
    m_a = 0;
    reset = 1;
    tick();
    reset = 0;
    checks++;
    if (obs_a !== 53'h0) begin
      errors++;
      $display("FAIL reset_mid: got %h expected %h", obs_a, 53'h0);
    end
  endtask

  task automatic test_ts_wrap();
    apply_reset();
    for (int cyc = 0; cyc <= 18; cyc++) begin
      m_b = (cyc == 14 || cyc == 17);
      tick();
      checks++;
      if (obs_b !== exp_vec(1)) begin
        errors++;
        $display("FAIL ts_wrap cyc %0d: got %h expected %h", cyc, obs_b, exp_vec(1));
      end
    end
    m_b = 0;
    checks++;
    if (!(v_b === 1'b1 && ts_b === 4'd14 && cnt_b === 4'd1)) begin
      errors++;
      $display("FAIL ts_wrap_first: got ts=%0d cnt=%0d expected ts=14 cnt=1", ts_b, cnt_b);
    end
    r_b = 1;
    tick();
    checks++;
    if (!(v_b === 1'b1 && ts_b === 4'd1 && cnt_b === 4'd2)) begin
      errors++;
      $display("FAIL ts_wrap_second: got ts=%0d cnt=%0d expected ts=1 cnt=2", ts_b, cnt_b);
    end
    idle_inputs();
  endtask

  task automatic test_saturate();
    apply_reset();
    r_b = 1;
    m_b = 1;
    for (int k = 1; k <= 17; k++) begin
      tick();
      checks++;
      if (obs_b !== exp_vec(1) || cnt_b !== 4'((k < 15) ? k : 15) ||
          tot_b !== 4'((k < 15) ? k : 15) || fill_b !== 3'd1) begin
        errors++;
        $display("FAIL saturate ev %0d: got cnt=%0d total=%0d fill=%0d expected cnt=%0d total=%0d fill=1",
                 k, cnt_b, tot_b, fill_b, (k < 15) ? k : 15, (k < 15) ? k : 15);
      end
    end
    idle_inputs();
  endtask

  task automatic test_random();
    apply_reset();
    for (int n = 0; n < 600; n++) begin
      m_a = 1'($urandom_range(0, 1));
      r_a = ($urandom_range(0, 3) != 0) ? (n % 64 < 40) : 1'b0;
      c_a = ($urandom_range(0, 63) == 0);
      m_b = ($urandom_range(0, 3) != 0);
      r_b = 1'($urandom_range(0, 1));
      c_b = ($urandom_range(0, 79) == 0);
      tick();
      checks++;
      if (obs_a !== exp_vec(0)) begin
        errors++;
        $display("FAIL random_a step %0d: got %h expected %h", n, obs_a, exp_vec(0));
      end
      checks++;
      if (obs_b !== exp_vec(1)) begin
        errors++;
        $display("FAIL random_b step %0d: got %h expected %h", n, obs_b, exp_vec(1));
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_full_pop();
    test_clear();
    test_reset_mid();
    test_ts_wrap();
    test_saturate();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
